// File: rtl/fpu_issue_ctrl_pkg.sv
// FPU_pkg: op codes, flag positions and the op-to-unit map shared by the FPU issue path.
package FPU_pkg;
  localparam int UNIT_W = 3;
  typedef logic [UNIT_W-1:0] unit_t;
  localparam unit_t UNIT_ILLEGAL = '1;
  localparam logic [4:0] FPU_OP_ADD  = 5'd0;
  localparam logic [4:0] FPU_OP_SUB  = 5'd1;
  localparam logic [4:0] FPU_OP_MUL  = 5'd2;
  localparam logic [4:0] FPU_OP_DIV  = 5'd3;
  localparam logic [4:0] FPU_OP_SQRT = 5'd4;
  localparam logic [4:0] FPU_OP_MIN  = 5'd5;
  localparam logic [4:0] FPU_OP_MAX  = 5'd6;
  localparam logic [4:0] FPU_OP_SGNJ = 5'd7;
  localparam logic [4:0] FPU_OP_CMP  = 5'd8;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [31:0] QNAN      = 32'h7fc0_0000;
  localparam logic [4:0]  NAN_FLAGS = 5'(1 << FLAG_NV);
  typedef struct packed {
    logic [31:0] f;
    logic [4:0]  flags;
  } result_t;
  function automatic unit_t fpu_unit_sel(input logic [4:0] op);
    return (op == FPU_OP_ADD || op == FPU_OP_SUB)  ? unit_t'(0) :
           (op == FPU_OP_MUL)                      ? unit_t'(1) :
           (op == FPU_OP_DIV || op == FPU_OP_SQRT) ? unit_t'(2) :
           (op inside {FPU_OP_MIN, FPU_OP_MAX, FPU_OP_SGNJ, FPU_OP_CMP}) ? unit_t'(3) :
           UNIT_ILLEGAL;
  endfunction
endpackage

// File: rtl/fpu_order_fifo.sv
// fpu_order_fifo: remembers which unit each issued op went to, so results retire in issue order.
module fpu_order_fifo
  import FPU_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  unit_t din,
  output logic  full,
  output logic  empty,
  output unit_t head
);
  localparam int AW = $clog2(DEPTH);
  unit_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: dispatches ops to FPU units and retires their results strictly in issue order.
module fpu_issue_ctrl
  import FPU_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [4:0]                 op,
  input  logic [31:0]                a,
  input  logic [31:0]                b,
  output logic [NUM_UNITS-1:0]       unit_valid,
  input  logic [NUM_UNITS-1:0]       unit_ready,
  output logic [4:0]                 unit_op,
  output logic [31:0]                unit_a,
  output logic [31:0]                unit_b,
  input  logic [NUM_UNITS-1:0]       res_valid,
  output logic [NUM_UNITS-1:0]       res_ready,
  input  logic [NUM_UNITS-1:0][31:0] res_float,
  input  logic [NUM_UNITS-1:0][4:0]  res_flags,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [31:0]                float_out,
  output logic [4:0]                 fflags
);
  unit_t sel, head;
  logic full, empty, push, pop, sel_ready, head_valid, slot_free;
  result_t head_res;
  assign sel       = fpu_unit_sel(op);
  assign unit_op   = op;
  assign unit_a    = a;
  assign unit_b    = b;
  assign slot_free = !valid_out || ready_in;
  // An index with no unit behind it never waits on a unit: it issues and retires as a quiet NaN.
  always_comb begin
    unit_valid = '0;
    res_ready  = '0;
    sel_ready  = int'(sel) >= NUM_UNITS;
    head_valid = int'(head) >= NUM_UNITS;
    head_res   = {QNAN, NAN_FLAGS};
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_valid[i] = valid_in && !full && sel == unit_t'(i);
      res_ready[i]  = !empty && head == unit_t'(i) && slot_free;
      if (sel == unit_t'(i)) sel_ready = unit_ready[i];
      if (head == unit_t'(i)) begin
        head_valid = res_valid[i];
        head_res   = {res_float[i], res_flags[i]};
      end
    end
  end
  assign ready_out = !full && sel_ready;
  assign push      = valid_in && ready_out;
  assign pop       = !empty && slot_free && head_valid;
  fpu_order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (sel),
    .full (full),
    .empty(empty),
    .head (head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_out <= 1'b0;
      float_out <= '0;
      fflags    <= '0;
    end else if (pop) begin
      valid_out <= 1'b1;
      float_out <= head_res.f;
      fflags    <= head_res.flags;
    end else if (ready_in) begin
      valid_out <= 1'b0;
      float_out <= '0;
      fflags    <= '0;
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: bench-side FPU unit models plus an in-order scoreboard around fpu_issue_ctrl.
module tb_fpu_issue_ctrl;
  import FPU_pkg::*;
  localparam int NU = 4;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, valid_in = 0, ready_in = 1;
  logic [4:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic ready_out, valid_out;
  logic [NU-1:0] unit_valid, res_ready;
  logic [NU-1:0] unit_ready = '0, res_valid = '0;
  logic [4:0] unit_op, fflags;
  logic [31:0] unit_a, unit_b, float_out;
  logic [NU-1:0][31:0] res_float = '0;
  logic [NU-1:0][4:0] res_flags = '0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.NUM_UNITS(NU), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .op(op), .a(a), .b(b),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_float(res_float), .res_flags(res_flags),
    .valid_out(valid_out), .ready_in(ready_in), .float_out(float_out), .fflags(fflags)
  );

  typedef struct {
    logic [36:0] r;
    int          t;
  } ent_t;
  typedef struct {
    logic [4:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [NU-1:0] mask;
    logic [36:0]   res;
  } vec_t;

  ent_t uq[NU][$];
  int lat[NU] = '{1, 2, 6, 1};
  bit hold[NU];
  logic [36:0] exp_q[$];
  logic [31:0] out_log[$];
  int checks = 0, errors = 0, cyc = 0;
  bit pend;
  logic [36:0] pend_val;
  bit l_issue, l_out, l_res, l_rdy;

  function automatic int umap(input logic [4:0] o);
    case (o)
      FPU_OP_ADD, FPU_OP_SUB: return 0;
      FPU_OP_MUL: return 1;
      FPU_OP_DIV, FPU_OP_SQRT: return 2;
      FPU_OP_MIN, FPU_OP_MAX, FPU_OP_SGNJ, FPU_OP_CMP: return 3;
      default: return -1;
    endcase
  endfunction

  // What the bench's own units compute: {flags, float}
  function automatic logic [36:0] unit_fn(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == FPU_OP_MIN) return {5'd0, (x < y) ? x : y};
    if (o == FPU_OP_MAX) return {5'd0, (x < y) ? y : x};
    return {x[4:0] ^ y[4:0] ^ o, x + y + 32'(o)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_units();
    for (int i = 0; i < NU; i++) begin
      unit_ready[i] = uq[i].size() < 4;
      res_valid[i] = 1'b0;
      res_float[i] = '0;
      res_flags[i] = '0;
      if (uq[i].size() > 0) begin
        res_valid[i] = !hold[i] && cyc >= uq[i][0].t;
        {res_flags[i], res_float[i]} = uq[i][0].r;
      end
    end
  endtask

  task automatic tick();
    bit hs_res[NU];
    bit hs_unit[NU];
    logic [4:0] so;
    logic [31:0] sa, sb;
    int u;
    drive_units();
    #1;
    if (pend) begin
      chk("load_latency", {valid_out, fflags, float_out}, {1'b1, pend_val});
      pend = 0;
    end
    l_rdy = ready_out;
    l_issue = valid_in && ready_out;
    l_out = valid_out && ready_in;
    l_res = 0;
    chk("res_ready_onehot", 64'($countones(res_ready) <= 1), 1);
    if (l_issue) begin
      u = umap(op);
      chk("unit_valid", unit_valid, (u < 0) ? 0 : (1 << u));
      chk("pass_ab", {unit_a, unit_b}, {a, b});
      chk("pass_op", unit_op, op);
      exp_q.push_back((u < 0) ? {5'b10000, 32'h7fc00000} : unit_fn(op, a, b));
    end
    if (l_out) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("order_data", {fflags, float_out}, exp_q.pop_front());
      out_log.push_back(float_out);
    end
    for (int i = 0; i < NU; i++) begin
      hs_res[i] = res_valid[i] && res_ready[i];
      hs_unit[i] = unit_valid[i] && unit_ready[i];
      if (hs_res[i]) begin
        l_res = 1;
        pend = 1;
        pend_val = {res_flags[i], res_float[i]};
      end
    end
    so = op; sa = a; sb = b;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NU; i++) begin
      if (hs_res[i]) uq[i].delete(0);
      if (hs_unit[i]) uq[i].push_back('{unit_fn(so, sa, sb), cyc + lat[i] - 1});
    end
  endtask

  task automatic do_reset();
    reset = 1;
    valid_in = 0;
    ready_in = 1;
    op = FPU_OP_ADD;
    for (int i = 0; i < NU; i++) begin
      uq[i].delete();
      hold[i] = 0;
    end
    exp_q.delete();
    out_log.delete();
    pend = 0;
    drive_units();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 30 && !valid_out; k++) tick();
    chk("valid_out_timeout", valid_out, 1);
  endtask

  task automatic drain();
    valid_in = 0;
    ready_in = 1;
    for (int i = 0; i < NU; i++) hold[i] = 0;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || valid_out); k++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; valid_in = 1;
    tick();
    valid_in = 0;
  endtask

  initial begin
    vec_t vecs[7];
    logic [36:0] v;
    vecs[0] = '{FPU_OP_MIN, 32'h3f800000, 32'h40000000, 4'b1000, {5'd0, 32'h3f800000}};
    vecs[1] = '{FPU_OP_MAX, 32'h3f800000, 32'h40000000, 4'b1000, {5'd0, 32'h40000000}};
    vecs[2] = '{FPU_OP_ADD, 32'h10, 32'h20, 4'b0001, {5'h10, 32'h30}};
    vecs[3] = '{FPU_OP_MUL, 32'h100, 32'h3, 4'b0010, {5'h01, 32'h105}};
    vecs[4] = '{FPU_OP_DIV, 32'h3f800000, 32'h0, 4'b0100, {5'h03, 32'h3f800003}};
    vecs[5] = '{5'd20, 32'h1234, 32'h5678, 4'b0000, {5'b10000, 32'h7fc00000}};
    vecs[6] = '{5'd31, 32'hffffffff, 32'h1, 4'b0000, {5'b10000, 32'h7fc00000}};

    do_reset();
    #1;
    chk("reset_valid_out", valid_out, 0);
    chk("reset_float_out", float_out, 0);
    chk("reset_fflags", fflags, 0);
    chk("reset_res_ready", res_ready, 0);
    chk("reset_ready_out", ready_out, 1);

    foreach (vecs[k]) begin
      op = vecs[k].op; a = vecs[k].a; b = vecs[k].b; valid_in = 1;
      #1;
      chk("vec_unit_valid", unit_valid, vecs[k].mask);
      chk("vec_ready_out", ready_out, 1);
      tick();
      valid_in = 0;
      wait_valid();
      chk("vec_result", {fflags, float_out}, vecs[k].res);
      tick();
      chk("vec_drain_zero", {valid_out, fflags, float_out}, 0);
    end

    // slow DIV ahead of fast MIN must retire first
    out_log.delete();
    issue(FPU_OP_DIV, 32'h40000000, 32'h3f800000);
    issue(FPU_OP_MIN, 32'h1, 32'h2);
    for (int k = 0; k < 30 && (exp_q.size() != 0 || valid_out); k++) begin
      if (uq[2].size() > 0) chk("min_held", res_ready[3], 0);
      tick();
    end
    chk("order_count", out_log.size(), 2);
    if (out_log.size() >= 2) begin
      v = unit_fn(FPU_OP_DIV, 32'h40000000, 32'h3f800000);
      chk("order_first_div", out_log[0], v[31:0]);
      chk("order_second_min", out_log[1], 1);
    end

    // fill the order FIFO with results stalled
    for (int i = 0; i < NU; i++) hold[i] = 1;
    for (int k = 0; k < 4; k++) begin
      op = (k == 0) ? FPU_OP_ADD : (k == 1) ? FPU_OP_MUL : (k == 2) ? FPU_OP_DIV : FPU_OP_MIN;
      a = 32'(k + 5); b = 32'(k * 3); valid_in = 1;
      #1 chk("fill_ready", ready_out, 1);
      tick();
    end
    op = FPU_OP_MAX; a = 32'h77; b = 32'h88;
    #1 chk("full_ready", ready_out, 0);
    tick();
    chk("full_no_issue", l_issue, 0);
    hold[0] = 0;
    tick();
    chk("pop_only_res", l_res, 1);
    chk("pop_only_ready", l_rdy, 0);
    tick();
    chk("after_pop_ready", l_rdy, 1);
    chk("after_pop_issue", l_issue, 1);
    drain();

    // output stall holds data steady, then drains back to back
    ready_in = 0;
    issue(FPU_OP_MIN, 32'h10, 32'h100);
    issue(FPU_OP_MIN, 32'h200, 32'h20);
    issue(FPU_OP_MIN, 32'h30, 32'h300);
    wait_valid();
    v = {fflags, float_out};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_stable", {valid_out, fflags, float_out}, {1'b1, v});
      chk("stall_res_ready", res_ready, 0);
    end
    ready_in = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_out", l_out, 1);
    end
    drain();

    // reset with entries in flight
    ready_in = 0;
    issue(FPU_OP_ADD, 32'h1, 32'h2);
    hold[1] = 1;
    issue(FPU_OP_MUL, 32'h3, 32'h4);
    issue(FPU_OP_DIV, 32'h5, 32'h6);
    chk("pre_reset_valid", valid_out, 1);
    reset = 1;
    #1 chk("reset_async_valid", valid_out, 0);
    do_reset();
    #1;
    chk("post_reset_ready", ready_out, 1);
    chk("post_reset_res_ready", res_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_reset_idle", valid_out, 0);
    end

    // randomized traffic against the scoreboard
    for (int n = 0; n < 800; n++) begin
      valid_in = 1'($urandom_range(0, 1));
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
      a = $urandom;
      b = $urandom;
      ready_in = $urandom_range(0, 3) != 0;
      for (int i = 0; i < NU; i++) hold[i] = $urandom_range(0, 7) == 0;
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
